// File: rtl/my_struct_package.sv
// Shared types and sizing for the set-associative cache lookup block.
package my_struct_package;
    localparam int WAYS        = 8;
    localparam int SETS        = 16;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = 32;
    localparam int INDEX_BITS  = $clog2(SETS);
    localparam int WAY_BITS    = $clog2(WAYS);
    localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int DATA_BITS   = 32;

    localparam logic [3:0] CMD_CLEAR = 4'd8;

    // I encodes as zero so an all-zero line is an invalid line
    typedef enum logic [1:0] {I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11} states_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, CLEAR} fsm_state_t;

    typedef struct packed {
        logic [3:0]           n;
        logic [ADDR_BITS-1:0] address;
    } command_t;

    typedef struct packed {
        logic [TAG_BITS-1:0]  tag;
        states_t              MESI_bits;
        logic [WAY_BITS-1:0]  LRU;
        logic [DATA_BITS-1:0] data;
    } cache_line_t;

    function automatic logic is_local_cmd(input logic [3:0] n);
        return n <= 4'd2;
    endfunction
endpackage

// File: rtl/cache_lookup_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and path update toward the accessed way.
module plru_tree #(
    parameter int WAYS     = 8,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]     bits,
    input  logic [WAY_BITS-1:0] access_way,
    output logic [WAY_BITS-1:0] victim,
    output logic [WAYS-2:0]     bits_next
);
    logic [WAY_BITS-1:0] node_v;
    logic [WAY_BITS-1:0] node_u;

    // Heap layout: children of node k are 2k+1 (left) and 2k+2 (right)
    always_comb begin
        victim = '0;
        node_v = '0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            victim[WAY_BITS-1-lvl] = bits[node_v];
            node_v = (node_v << 1) + WAY_BITS'(1) + {{(WAY_BITS-1){1'b0}}, bits[node_v]};
        end
    end

    always_comb begin
        bits_next = bits;
        node_u    = '0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            bits_next[node_u] = ~access_way[WAY_BITS-1-lvl];
            node_u = (node_u << 1) + WAY_BITS'(1)
                     + {{(WAY_BITS-1){1'b0}}, access_way[WAY_BITS-1-lvl]};
        end
    end
endmodule

// File: rtl/cache_lookup.sv
// Set-associative tag lookup with MESI line hand-off, pLRU allocation and a bulk clear walk.
//  state  | meaning
//  IDLE   | ready for a command
//  LOOKUP | tag compare, hit/hitM and selected line presented
//  APPLY  | write back line from MESI FSM, update pLRU, pulse done
//  CLEAR  | invalidate one set per cycle, done after the last set
module cache_lookup #(
    parameter int WAYS        = 8,
    parameter int SETS        = 16,
    parameter int OFFSET_BITS = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  my_struct_package::command_t            instruction,
    output logic                                   hit,
    output logic                                   hitM,
    output my_struct_package::cache_line_t         internal_line,
    input  my_struct_package::cache_line_t         return_line,
    output logic                                   done,
    output logic                                   evict,
    output logic [my_struct_package::TAG_BITS-1:0] evict_tag
);
    import my_struct_package::*;

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    typedef cache_line_t [WAYS-1:0] set_t;

    fsm_state_t                 state_q, state_d;
    command_t                   cmd_q;
    logic [IDX_W:0]             clr_q;
    set_t [SETS-1:0]            lines_q;
    logic [SETS-1:0][WAYS-2:0]  plru_q;

    logic [IDX_W-1:0]    idx;
    logic [TAG_BITS-1:0] tag;
    logic                hit_any, inv_found, is_local, is_snoop, alloc, wr_en, in_cmd, clr_last;
    logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, sel_way;
    logic [WAYS-2:0]     plru_next;
    cache_line_t         sel_line;
    logic                unused_offset;

    function automatic set_t invalidate_set(input set_t s);
        set_t r;
        r = s;
        for (int w = 0; w < WAYS; w++) r[w].MESI_bits = I;
        return r;
    endfunction

    assign idx           = cmd_q.address[OFFSET_BITS +: IDX_W];
    assign tag           = cmd_q.address[ADDR_BITS-1 -: TAG_BITS];
    assign unused_offset = ^cmd_q.address[OFFSET_BITS-1:0];

    // Descending scan so the lowest matching / invalid way wins
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (lines_q[idx][w].MESI_bits != I && lines_q[idx][w].tag == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (lines_q[idx][w].MESI_bits == I) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    plru_tree #(.WAYS(WAYS), .WAY_BITS(WAY_W)) u_plru (
        .bits       (plru_q[idx]),
        .access_way (sel_way),
        .victim     (plru_victim),
        .bits_next  (plru_next)
    );

    assign is_local = is_local_cmd(cmd_q.n);
    assign is_snoop = (cmd_q.n == 4'd3) || (cmd_q.n == 4'd4);
    assign alloc    = is_local && !hit_any;
    assign sel_way  = hit_any ? hit_way : (inv_found ? inv_way : plru_victim);
    assign wr_en    = (hit_any && (is_local || is_snoop)) || alloc;
    assign sel_line = lines_q[idx][sel_way];
    assign in_cmd   = (state_q == LOOKUP) || (state_q == APPLY);
    assign clr_last = (clr_q == (IDX_W+1)'(SETS));

    always_comb begin
        internal_line = '0;
        if (in_cmd) begin
            if (hit_any) begin
                internal_line = sel_line;
            end else if (alloc) begin
                internal_line.tag       = tag;
                internal_line.MESI_bits = I;
                internal_line.LRU       = sel_line.LRU;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign hit       = (state_q == LOOKUP) && hit_any;
    assign hitM      = hit && (sel_line.MESI_bits == M);
    assign done      = !rst && ((state_q == APPLY) || (state_q == CLEAR && clr_last));
    assign evict     = !rst && (state_q == APPLY) && alloc && (sel_line.MESI_bits == M);
    assign evict_tag = evict ? sel_line.tag : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = (instruction.n == CMD_CLEAR) ? CLEAR : LOOKUP;
            LOOKUP:  state_d = APPLY;
            APPLY:   state_d = IDLE;
            CLEAR:   if (clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            clr_q   <= '0;
            lines_q <= '0;
            plru_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                cmd_q <= instruction;
                clr_q <= '0;
            end
            if (state_q == APPLY && wr_en) lines_q[idx][sel_way] <= return_line;
            if (state_q == APPLY && is_local) plru_q[idx] <= plru_next;
            if (state_q == CLEAR && !clr_last) begin
                lines_q[clr_q[IDX_W-1:0]] <= invalidate_set(lines_q[clr_q[IDX_W-1:0]]);
                plru_q[clr_q[IDX_W-1:0]]  <= '0;
                clr_q                     <= clr_q + (IDX_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_cache_lookup.sv
// Directed bench for cache_lookup; the bench plays the downstream MESI FSM via return_line.
module tb_cache_lookup;
    import my_struct_package::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    command_t            instruction;
    logic                hit, hitM, done, evict;
    cache_line_t         internal_line, return_line;
    logic [TAG_BITS-1:0] evict_tag;

    int checks = 0;
    int errors = 0;

    logic        r_hit, r_hitm, r_done_lk, r_done, r_evict;
    logic [TAG_BITS-1:0] r_evtag;
    cache_line_t r_line;

    cache_lookup #(.WAYS(8), .SETS(16), .OFFSET_BITS(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .instruction   (instruction),
        .hit           (hit),
        .hitM          (hitM),
        .internal_line (internal_line),
        .return_line   (return_line),
        .done          (done),
        .evict         (evict),
        .evict_tag     (evict_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int t, input int s);
        logic [21:0] tt;
        logic [3:0]  ss;
        tt = t[21:0];
        ss = s[3:0];
        return {tt, ss, 6'b0};
    endfunction

    function automatic int valid_lines();
        int c;
        c = 0;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 8; w++)
                if (dut.lines_q[s][w].MESI_bits != I) c++;
        return c;
    endfunction

    // One full command: accept, sample LOOKUP outputs, return a line, sample APPLY outputs
    task automatic issue(input logic [3:0] n, input logic [31:0] addr, input states_t ret);
        chk("ready_idle", cmd_ready, 1);
        instruction.n       = n;
        instruction.address = addr;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        r_hit     = hit;
        r_hitm    = hitM;
        r_line    = internal_line;
        r_done_lk = done;
        return_line           = internal_line;
        return_line.tag       = addr[31:10];
        return_line.MESI_bits = ret;
        return_line.data      = addr;
        @(posedge clk); #1;
        @(negedge clk);
        r_done  = done;
        r_evict = evict;
        r_evtag = evict_tag;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        instruction = '0;
        return_line = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_evict", evict, 0);
        chk("rst_hit", hit, 0);
        chk("rst_iline", internal_line, 0);
        chk("rst_valid", valid_lines(), 0);

        // first read into set 1 allocates way 0, victim moves to way 4
        issue(4'd0, 32'h0000_1040, M);
        chk("r1_hit", r_hit, 0);
        chk("r1_done_lookup", r_done_lk, 0);
        chk("r1_tag", r_line.tag, 4);
        chk("r1_mesi", r_line.MESI_bits, I);
        chk("r1_done", r_done, 1);
        chk("r1_evict", r_evict, 0);
        chk("r1_plru", dut.plru_q[1], 7'b0001011);
        chk("r1_way0_tag", dut.lines_q[1][0].tag, 4);
        chk("r1_victim", dut.u_plru.victim, 4);

        issue(4'd0, 32'h0000_1040, M);
        chk("r2_hit", r_hit, 1);
        chk("r2_hitm", r_hitm, 1);
        chk("r2_plru", dut.plru_q[1], 7'b0001011);

        for (int t = 5; t <= 11; t++) begin
            issue(4'd0, mk(t, 1), E);
            chk("fill_hit", r_hit, 0);
            chk("fill_evict", r_evict, 0);
        end
        chk("fill_plru", dut.plru_q[1], 7'b0000000);
        chk("fill_way7_tag", dut.lines_q[1][7].tag, 11);

        issue(4'd0, mk(12, 1), E);
        chk("evict_hit", r_hit, 0);
        chk("evict_flag", r_evict, 1);
        chk("evict_tag", r_evtag, 4);
        chk("evict_newtag", r_line.tag, 12);
        chk("evict_way0", dut.lines_q[1][0].tag, 12);

        // write then snoop-invalidate in set 0
        issue(4'd1, 32'h0000_2000, M);
        chk("wr_hit", r_hit, 0);
        issue(4'd4, 32'h0000_2000, I);
        chk("snp4_hit", r_hit, 1);
        chk("snp4_hitm", r_hitm, 1);
        chk("snp4_done_lookup", r_done_lk, 0);
        chk("snp4_done", r_done, 1);
        chk("snp4_plru", dut.plru_q[0], 7'b0001011);
        issue(4'd0, 32'h0000_2000, S);
        chk("after_snp4_hit", r_hit, 0);

        issue(4'd3, 32'h0000_3000, M);
        chk("snp3_hit", r_hit, 0);
        chk("snp3_iline", r_line, 0);
        chk("snp3_done", r_done, 1);
        chk("snp3_way1", dut.lines_q[0][1].MESI_bits, I);
        chk("snp3_way0", dut.lines_q[0][0].MESI_bits, S);
        issue(4'd0, 32'h0000_3000, E);
        chk("after_snp3_hit", r_hit, 0);

        issue(4'd5, mk(12, 1), I);
        chk("unk_hit", r_hit, 1);
        chk("unk_hitm", r_hitm, 0);
        chk("unk_done", r_done, 1);
        chk("unk_evict", r_evict, 0);
        issue(4'd0, mk(12, 1), E);
        chk("after_unk_hit", r_hit, 1);

        // bulk clear
        issue(4'd0, 32'h0000_0080, E);
        instruction.n       = 4'd8;
        instruction.address = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk("clr_ready", cmd_ready, 0);
            chk("clr_done_early", done, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("clr_done17", done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_ready_after", cmd_ready, 1);
        chk("clr_done_after", done, 0);
        chk("clr_valid", valid_lines(), 0);
        chk("clr_plru1", dut.plru_q[1], 7'b0000000);
        issue(4'd0, 32'h0000_2000, E);
        chk("clr_rd0_hit", r_hit, 0);
        issue(4'd0, mk(12, 1), E);
        chk("clr_rd1_hit", r_hit, 0);
        issue(4'd0, 32'h0000_0080, E);
        chk("clr_rd2_hit", r_hit, 0);

        // reset during the clear walk
        issue(4'd0, mk(1, 10), M);
        chk("pre_rst_valid", valid_lines(), 4);
        instruction.n = 4'd8;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_clr_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clr_ready", cmd_ready, 1);
        chk("rst_clr_done2", done, 0);
        chk("rst_clr_valid", valid_lines(), 0);

        // reset during APPLY
        issue(4'd0, mk(1, 10), M);
        instruction.n       = 4'd0;
        instruction.address = mk(2, 10);
        return_line         = '0;
        return_line.tag     = 22'd2;
        return_line.MESI_bits = M;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_apply_done", done, 0);
        chk("rst_apply_evict", evict, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_apply_ready", cmd_ready, 1);
        chk("rst_apply_done2", done, 0);
        chk("rst_apply_valid", valid_lines(), 0);
        chk("rst_apply_way1", dut.lines_q[10][1].tag, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
